// File: rtl/rot_mult_sched.sv
// Shared rotator-multiplier scheduler: packs two trellis requesters into the multiplier's
// two-cycle slot and returns tagged results. Define ROT_SCHED_RR_EN for round-robin grants.
module rot_mult_sched #(
    parameter  int unsigned MULT_LAT = 7,
    parameter  int unsigned TAG_W    = 4,
    localparam int unsigned DATA_W   = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_re_i,
    input  logic [DATA_W-1:0] req0_im_i,
    input  logic [DATA_W-1:0] req0_cos_i,
    input  logic [DATA_W-1:0] req0_sin_i,
    input  logic [TAG_W-1:0]  req0_tag_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_re_i,
    input  logic [DATA_W-1:0] req1_im_i,
    input  logic [DATA_W-1:0] req1_cos_i,
    input  logic [DATA_W-1:0] req1_sin_i,
    input  logic [TAG_W-1:0]  req1_tag_i,

    output logic              mult_ena_o,
    output logic [DATA_W-1:0] mult_a_o,
    output logic [DATA_W-1:0] mult_b_o,
    output logic [DATA_W-1:0] mult_c_o,
    output logic [DATA_W-1:0] mult_d_o,
    input  logic [DATA_W-1:0] mult_re0_i,
    input  logic [DATA_W-1:0] mult_im0_i,
    input  logic [DATA_W-1:0] mult_re1_i,
    input  logic [DATA_W-1:0] mult_im1_i,

    output logic              res_valid_o,
    output logic              res_id_o,
    output logic [TAG_W-1:0]  res_tag_o,
    output logic [DATA_W-1:0] res_re_o,
    output logic [DATA_W-1:0] res_im_o
);

    localparam int unsigned DEPTH = MULT_LAT + 1;

    typedef enum logic {
        SLOT_A = 1'b0,
        SLOT_B = 1'b1
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             id;
        logic [TAG_W-1:0] tag;
    } trk_t;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic [DATA_W-1:0] cos;
        logic [DATA_W-1:0] sin;
    } ops_t;

    state_e            state_q, state_d;
    logic              slot_open_c;
    logic              gnt0_c, gnt1_c, gnt_any_c;
    logic              ena_q, ena_d;
    ops_t              ops_q, ops_d;
    trk_t              trk_q [DEPTH];
    trk_t              trk_d;
    logic              res_valid_q, res_valid_d;
    logic              res_id_q, res_id_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic [DATA_W-1:0] res_re_q, res_re_d;
    logic [DATA_W-1:0] res_im_q, res_im_d;

`ifdef ROT_SCHED_RR_EN
    // last_q=1 means req1 was granted most recently, so req0 wins the next tie.
    logic last_q, last_d;
`endif

    // Arbitration: SLOT_B always completes, SLOT_A only opens while enabled.
    always_comb begin
        slot_open_c = !reset_i && ((state_q == SLOT_B) || enable_i);
`ifdef ROT_SCHED_RR_EN
        if (req0_valid_i && req1_valid_i) begin
            gnt0_c = slot_open_c && last_q;
            gnt1_c = slot_open_c && !last_q;
        end else begin
            gnt0_c = slot_open_c && req0_valid_i;
            gnt1_c = slot_open_c && req1_valid_i;
        end
`else
        gnt0_c = slot_open_c && req0_valid_i;
        gnt1_c = slot_open_c && req1_valid_i && !req0_valid_i;
`endif
        gnt_any_c = gnt0_c || gnt1_c;
    end

    assign req0_ready_o = gnt0_c;
    assign req1_ready_o = gnt1_c;

`ifdef ROT_SCHED_RR_EN
    always_comb begin
        last_d = last_q;
        if (gnt_any_c) begin
            last_d = gnt1_c;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Slot sequencing and operand issue; an ungranted half goes out as zeros.
    always_comb begin
        state_d = state_q;
        ena_d   = 1'b0;
        ops_d   = '0;
        trk_d   = '0;
        if (gnt_any_c) begin
            ops_d.re    = gnt1_c ? req1_re_i  : req0_re_i;
            ops_d.im    = gnt1_c ? req1_im_i  : req0_im_i;
            ops_d.cos   = gnt1_c ? req1_cos_i : req0_cos_i;
            ops_d.sin   = gnt1_c ? req1_sin_i : req0_sin_i;
            trk_d.valid = 1'b1;
            trk_d.first = (state_q == SLOT_A);
            trk_d.id    = gnt1_c;
            trk_d.tag   = gnt1_c ? req1_tag_i : req0_tag_i;
        end
        case (state_q)
            SLOT_A: begin
                if (gnt_any_c) begin
                    state_d = SLOT_B;
                    ena_d   = 1'b1;
                end
            end
            SLOT_B:  state_d = SLOT_A;
            default: state_d = SLOT_A;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= SLOT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Result capture when a tracked half leaves the multiplier.
    always_comb begin
        res_valid_d = trk_q[DEPTH-1].valid;
        res_id_d    = res_id_q;
        res_tag_d   = res_tag_q;
        res_re_d    = res_re_q;
        res_im_d    = res_im_q;
        if (trk_q[DEPTH-1].valid) begin
            res_id_d  = trk_q[DEPTH-1].id;
            res_tag_d = trk_q[DEPTH-1].tag;
            res_re_d  = trk_q[DEPTH-1].first ? mult_re0_i : mult_re1_i;
            res_im_d  = trk_q[DEPTH-1].first ? mult_im0_i : mult_im1_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ena_q       <= 1'b0;
            ops_q       <= '0;
            trk_q       <= '{default: '0};
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_tag_q   <= '0;
            res_re_q    <= '0;
            res_im_q    <= '0;
        end else begin
            ena_q    <= ena_d;
            ops_q    <= ops_d;
            trk_q[0] <= trk_d;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                trk_q[k] <= trk_q[k-1];
            end
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_tag_q   <= res_tag_d;
            res_re_q    <= res_re_d;
            res_im_q    <= res_im_d;
        end
    end

    assign mult_ena_o  = ena_q;
    assign mult_a_o    = ops_q.re;
    assign mult_b_o    = ops_q.im;
    assign mult_c_o    = ops_q.cos;
    assign mult_d_o    = ops_q.sin;
    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_tag_o   = res_tag_q;
    assign res_re_o    = res_re_q;
    assign res_im_o    = res_im_q;

    // Grant sanity: one owner per cycle, and never without a request.
    a_one_grant: assert property (@(posedge clk_i) disable iff (reset_i)
        !(req0_ready_o && req1_ready_o));
    a_grant_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        (!req0_ready_o || req0_valid_i) && (!req1_ready_o || req1_valid_i));

endmodule

// File: doc/rot_mult_sched.md
# rot_mult_sched

Scheduler for the shared rotator multiplier in the trellis path. It arbitrates between two requesters (trellis branch 0 and branch 1), each presenting a complex sample plus a rotation phasor. It packs granted operands into the multiplier's two-cycle slot (ena-marked first half, unmarked second half). It tracks ownership through the multiplier pipeline and returns each rotated result as one tagged result stream.

## Interface
- MULT_LAT, 7, cycles from the multiplier's ena-high cycle to its first/second outputs (reOut0/imOut0, reOut1/imOut1) being valid.
- TAG_W, 4, width of the per-operand tag carried alongside each request.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allows a new slot to start; a slot already in progress always completes.
- reqN_valid  in  1  (N=0,1) operand available.
- reqN_ready  out  1  combinational grant; the transfer happens when valid&ready.
- reqN_re, reqN_im  in  10  signed sample.
- reqN_cos, reqN_sin  in  10  signed phasor.
- reqN_tag  in  TAG_W  opaque tag, returned with the result.
- mult_ena  out  1  registered; high on the first-half cycle of a slot.
- mult_a, mult_b, mult_c, mult_d  out  10  registered operands (re, im, cos, sin).
- mult_re0, mult_im0, mult_re1, mult_im1  in  10  multiplier outputs.
- res_valid  out  1  result strobe; there is no backpressure.
- res_id  out  1  owning requester.
- res_tag  out  TAG_W  tag of the result.
- res_re, res_im  out  10  rotated sample.

## Operation
- The FSM has two states, SLOT_A and SLOT_B.
- **SLOT_A:**
  - If enable=1 and any reqN_valid, grant one requester, register its operands with mult_ena=1 next cycle, and go to SLOT_B.
  - Otherwise stay in SLOT_A, with mult_ena=0 and operands held at zero.
- **SLOT_B:**
  - If any reqN_valid (enable is ignored here), grant one requester and register its operands with mult_ena=0 next cycle.
  - Otherwise issue a bubble: zero operands, half marked invalid.
  - Always return to SLOT_A.
- Maximum throughput is one operand per cycle. Back-to-back slots are allowed.
- At most one ready is high per cycle, and a requester may own both halves of a slot.
- Arbitration is as set by the Configuration section. Grant requires valid; ready is never high without valid.
- **Tracking pipeline:** a shift register of depth MULT_LAT+1, one entry per issued cycle, holding {half_valid, is_first, id, tag}. An entry is pushed each cycle, invalid when nothing is issued.
- **Result capture:**
  - A first-half entry reaching depth MULT_LAT+1 captures mult_re0/mult_im0 into the result registers.
  - The matching second-half entry captures mult_re1/mult_im1 one cycle later.
  - An invalid half produces no res_valid.
- **Reset:**
  - FSM goes to SLOT_A and the tracking pipeline is cleared.
  - Data still in the multiplier pipeline is discarded and never produces res_valid.
  - The round-robin pointer is set to favour req0.

## Timing
- Reset values:
  - mult_ena=0, mult_a..d=0.
  - res_valid=0, res_id=0, res_tag=0, res_re=0, res_im=0.
  - reqN_ready=0 while reset is asserted.
- Latency: an operand granted at cycle g gives res_valid at cycle g+MULT_LAT+2. This is the same for both halves.
- A result is presented for exactly one cycle. Results are in grant order.
- res_re/res_im/res_tag/res_id hold their last value when res_valid=0.
- enable falling during SLOT_B: the second half is still granted/issued, and no new slot starts.
- Simultaneous valid on both requesters in the same cycle: only one is granted. The loser keeps valid and is granted no earlier than the next cycle.

## Configuration
- ROT_SCHED_RR_EN defined:
  - Round-robin per granted operand. When both are valid, grant the requester not granted most recently.
  - A single valid requester is always granted and updates the pointer.
- ROT_SCHED_RR_EN undefined:
  - Fixed priority: req0 is always granted when valid; req1 only when req0_valid=0.
  - No pointer state.

## Test plan
The bench instantiates the real multiplier with MULT_LAT=7.
- **Single operand and bubble:** req0 only, re=0x100, im=0, cos=0x1ff, sin=0, tag=3 -> ready0 at g; mult_ena at g+1 followed by a bubble half; res_valid at g+9 with id=0, tag=3, re=0x0ff, im=0x000; no second result.
- **Saturation and back-to-back slots:**
  - Stimulus: req1 streams 4 operands on consecutive cycles; the first is re=0x200, cos=0x200, sin=0.
  - Expected: mult_ena pattern 1,0,1,0; four res_valid on consecutive cycles with tags in order; first result re=0x1ff.
- **Arbitration, both valid continuously (RR_EN):** grants alternate 0,1,0,1. Without RR_EN, all grants go to req0 and ready1 stays 0.
- **enable dropped mid-slot:** deassert enable in the SLOT_B cycle -> the second half is still granted; no mult_ena afterwards until enable returns; both results appear.
- **Reset mid-operation:** assert reset 3 cycles after 2 grants -> outputs zero immediately; no res_valid for the in-flight operands; after release, a new grant gives a result at g+9.
